demux_ser: RTL and testbench

Parametrised single-clock successor to the system-side demultiplexer. It accepts wide master words on a ready/valid handshake and routes each word to one of `NUM_CH` output channels. On the selected channel it serialises the word into `MST_DWIDTH/SYS_DWIDTH` narrow beats, with per-channel backpressure. It sits between the master-side word interface and the per-algorithm decryption channels.

---
 rtl/demux_pkg.sv | 35 +++
 rtl/demux_ser_word_slicer.sv | 39 +++
 rtl/demux_ser.sv | 146 ++++++++++++++
 tb/tb_demux_ser.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/demux_pkg.sv
// Shared definitions for the word-to-beat demultiplexer: FSM encodings,
// width helpers and the parameter legality rule used at elaboration.
package demux_pkg;

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_SEND = 1'b1;

   // Smallest n with 2**n >= value; 0 for value <= 1.
   function automatic int clog2(input int value);
      int result;
      result = 0;
      for (int i = 0; i < 31; i++) begin
         if ((32'sd1 <<< i) < value) begin
            result = i + 1;
         end
      end
      return result;
   endfunction

   function automatic int sel_width(input int num_ch);
      return (clog2(num_ch) < 1) ? 1 : clog2(num_ch);
   endfunction

   function automatic bit params_legal(input int mst_dwidth, input int sys_dwidth,
                                       input int num_ch, input int msb_first);
      bit ok;
      ok = (sys_dwidth > 0) && (mst_dwidth > 0);
      if (ok) begin
         ok = ((mst_dwidth % sys_dwidth) == 0) && ((mst_dwidth / sys_dwidth) >= 2);
      end
      ok = ok && (num_ch >= 1) && ((msb_first == 0) || (msb_first == 1));
      return ok;
   endfunction

endpackage

// File: rtl/demux_ser_word_slicer.sv
// Combinational selection of one SYS_DWIDTH slice of the held word,
// ordered MSB-first or LSB-first by beat index.
module word_slicer
   import demux_pkg::*;
#(
   parameter int MST_DWIDTH = 32,
   parameter int SYS_DWIDTH = 8,
   parameter int MSB_FIRST  = 1,
   localparam int RATIO     = MST_DWIDTH / SYS_DWIDTH,
   localparam int BEAT_W    = clog2(RATIO)
) (
   input  logic [MST_DWIDTH-1:0] i_word,
   input  logic [BEAT_W-1:0]     i_beat,
   output logic [SYS_DWIDTH-1:0] o_slice
);

   localparam logic [BEAT_W:0] RATIO_L = (BEAT_W + 1)'(RATIO);

   logic [SYS_DWIDTH-1:0] w_slices [RATIO];

   for (genvar i = 0; i < RATIO; i++) begin : g_slice
      if (MSB_FIRST != 0) begin : g_msb
         assign w_slices[i] = i_word[MST_DWIDTH-1-i*SYS_DWIDTH -: SYS_DWIDTH];
      end else begin : g_lsb
         assign w_slices[i] = i_word[i*SYS_DWIDTH +: SYS_DWIDTH];
      end
   end

   // Beat index picks the slice; an index past the last slice yields zero.
   always_comb begin
      o_slice = {SYS_DWIDTH{1'b0}};
      if ({1'b0, i_beat} < RATIO_L) begin
         o_slice = w_slices[i_beat];
      end else begin
         o_slice = {SYS_DWIDTH{1'b0}};
      end
   end

endmodule

// File: rtl/demux_ser.sv
// Routes wide master words to one of NUM_CH channels and serialises each
// word there as RATIO narrow beats under per-channel ready/valid.
module demux_ser
   import demux_pkg::*;
#(
   parameter int MST_DWIDTH = 32,
   parameter int SYS_DWIDTH = 8,
   parameter int NUM_CH     = 3,
   parameter int MSB_FIRST  = 1,
   localparam int RATIO     = MST_DWIDTH / SYS_DWIDTH,
   localparam int SEL_W     = sel_width(NUM_CH),
   localparam int BEAT_W    = clog2(RATIO)
) (
   input  logic                         clk_sys,
   input  logic                         rst_n,
   input  logic [SEL_W-1:0]             select,
   input  logic [MST_DWIDTH-1:0]        data_i,
   input  logic                         valid_i,
   output logic                         ready_o,
   output logic [NUM_CH*SYS_DWIDTH-1:0] data_o,
   output logic [NUM_CH-1:0]            valid_o,
   input  logic [NUM_CH-1:0]            ready_i,
   output logic                         drop_o
);

   if (!params_legal(MST_DWIDTH, SYS_DWIDTH, NUM_CH, MSB_FIRST)) begin : g_param_error
      $error("demux_ser: illegal parameters MST_DWIDTH=%0d SYS_DWIDTH=%0d NUM_CH=%0d MSB_FIRST=%0d",
             MST_DWIDTH, SYS_DWIDTH, NUM_CH, MSB_FIRST);
   end

   localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(RATIO - 1);
   localparam logic [SEL_W:0]    NUM_CH_L  = (SEL_W + 1)'(NUM_CH);

   logic [0:0]                   r_state;
   logic [BEAT_W-1:0]            r_beat;
   logic [SEL_W-1:0]             r_ch;
   logic [MST_DWIDTH-1:0]        r_hold;
   logic                         r_drop;

   logic                         w_ch_ready;
   logic                         w_last;
   logic                         w_ready;
   logic                         w_accept;
   logic                         w_in_range;
   logic [SYS_DWIDTH-1:0]        w_slice;
   logic [NUM_CH-1:0]            w_valid;
   logic [NUM_CH*SYS_DWIDTH-1:0] w_data;

   word_slicer #(
      .MST_DWIDTH (MST_DWIDTH),
      .SYS_DWIDTH (SYS_DWIDTH),
      .MSB_FIRST  (MSB_FIRST)
   ) u_word_slicer (
      .i_word  (r_hold),
      .i_beat  (r_beat),
      .o_slice (w_slice)
   );

   // Ready of the currently owned channel; other channels' ready is ignored.
   always_comb begin
      w_ch_ready = 1'b0;
      for (int c = 0; c < NUM_CH; c++) begin
         w_ch_ready = w_ch_ready | (({1'b0, r_ch} == (SEL_W + 1)'(c)) & ready_i[c]);
      end
   end

   assign w_last     = (r_beat == LAST_BEAT);
   assign w_ready    = (r_state == ST_IDLE) | ((r_state == ST_SEND) & w_last & w_ch_ready);
   assign w_accept   = valid_i & w_ready;
   assign w_in_range = ({1'b0, select} < NUM_CH_L);

   // Word-level FSM: load, beat advance, back-to-back reload and drop.
   always_ff @(posedge clk_sys or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
         r_beat  <= {BEAT_W{1'b0}};
         r_ch    <= {SEL_W{1'b0}};
         r_hold  <= {MST_DWIDTH{1'b0}};
         r_drop  <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_accept && w_in_range) begin
                  r_state <= ST_SEND;
                  r_hold  <= data_i;
                  r_ch    <= select;
                  r_beat  <= {BEAT_W{1'b0}};
                  r_drop  <= 1'b0;
               end else begin
                  r_drop  <= w_accept;
               end
            end
            ST_SEND: begin
               if (w_ch_ready && w_last) begin
                  if (w_accept && w_in_range) begin
                     r_hold  <= data_i;
                     r_ch    <= select;
                     r_beat  <= {BEAT_W{1'b0}};
                     r_drop  <= 1'b0;
                  end else begin
                     r_state <= ST_IDLE;
                     r_beat  <= {BEAT_W{1'b0}};
                     r_drop  <= w_accept;
                  end
               end else if (w_ch_ready) begin
                  r_beat <= r_beat + BEAT_W'(1'b1);
                  r_drop <= 1'b0;
               end else begin
                  r_drop <= 1'b0;
               end
            end
            default: begin
               r_state <= ST_IDLE;
               r_beat  <= {BEAT_W{1'b0}};
               r_drop  <= 1'b0;
            end
         endcase
      end
   end

   // Lane fan-out: only the owned channel sees valid and the current slice.
   always_comb begin
      w_valid = {NUM_CH{1'b0}};
      w_data  = {(NUM_CH * SYS_DWIDTH){1'b0}};
      if (r_state == ST_SEND) begin
         for (int c = 0; c < NUM_CH; c++) begin
            if ({1'b0, r_ch} == (SEL_W + 1)'(c)) begin
               w_valid[c]                         = 1'b1;
               w_data[c*SYS_DWIDTH +: SYS_DWIDTH] = w_slice;
            end else begin
               w_valid[c]                         = 1'b0;
               w_data[c*SYS_DWIDTH +: SYS_DWIDTH] = {SYS_DWIDTH{1'b0}};
            end
         end
      end else begin
         w_valid = {NUM_CH{1'b0}};
         w_data  = {(NUM_CH * SYS_DWIDTH){1'b0}};
      end
   end

   assign valid_o = w_valid;
   assign data_o  = w_data;
   assign drop_o  = r_drop;
   assign ready_o = w_ready;

endmodule

// File: tb/tb_demux_ser.sv
// Self-checking bench for demux_ser: directed scenarios plus randomized
// traffic against a beat-queue reference model.
module tb_demux_ser;

   logic        clk_sys;
   logic        rst_n;
   logic [1:0]  select;
   logic [31:0] data_i;
   logic        valid_i;
   logic [2:0]  ready_i;
   logic        ready_o, lsb_ready_o;
   logic [23:0] data_o, lsb_data_o;
   logic [2:0]  valid_o, lsb_valid_o;
   logic        drop_o, lsb_drop_o;

   int vectors     = 0;
   int miscompares = 0;

   typedef struct {
      int         ch;
      logic [7:0] d;
   } beat_t;

   demux_ser #(.MST_DWIDTH(32), .SYS_DWIDTH(8), .NUM_CH(3), .MSB_FIRST(1)) dut (
      .clk_sys (clk_sys), .rst_n (rst_n), .select (select), .data_i (data_i),
      .valid_i (valid_i), .ready_o (ready_o), .data_o (data_o), .valid_o (valid_o),
      .ready_i (ready_i), .drop_o (drop_o)
   );

   demux_ser #(.MST_DWIDTH(32), .SYS_DWIDTH(8), .NUM_CH(3), .MSB_FIRST(0)) dut_lsb (
      .clk_sys (clk_sys), .rst_n (rst_n), .select (select), .data_i (data_i),
      .valid_i (valid_i), .ready_o (lsb_ready_o), .data_o (lsb_data_o), .valid_o (lsb_valid_o),
      .ready_i (ready_i), .drop_o (lsb_drop_o)
   );

   initial clk_sys = 1'b0;
   always #5 clk_sys = ~clk_sys;

   // Byte k of the word in transmission order.
   function automatic logic [7:0] exp_byte(input logic [31:0] w, input int k, input bit msb);
      int sh;
      sh = msb ? 8 * (3 - k) : 8 * k;
      return 8'((w >> sh) & 32'hFF);
   endfunction

   function automatic logic [23:0] lane(input logic [7:0] b, input int ch);
      return 24'(b) << (8 * ch);
   endfunction

   task automatic apply_reset();
      rst_n   = 1'b0;
      valid_i = 1'b0;
      select  = 2'd0;
      data_i  = 32'h0;
      ready_i = 3'b000;
      repeat (2) @(negedge clk_sys);
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      apply_reset();
      #1;
      vectors += 5;
      if (valid_o !== 3'b000) begin miscompares++; $display("FAIL reset_valid: got %b expected 000", valid_o); end
      if (data_o !== 24'h0) begin miscompares++; $display("FAIL reset_data: got %h expected 000000", data_o); end
      if (drop_o !== 1'b0) begin miscompares++; $display("FAIL reset_drop: got %b expected 0", drop_o); end
      if (ready_o !== 1'b1) begin miscompares++; $display("FAIL reset_ready: got %b expected 1", ready_o); end
      if (lsb_valid_o !== 3'b000) begin miscompares++; $display("FAIL reset_lsb_valid: got %b expected 000", lsb_valid_o); end
      @(negedge clk_sys);
   endtask

   task automatic test_single();
      logic [31:0] w;
      w = 32'hA1B2C3D4;
      apply_reset();
      data_i = w; select = 2'd1; valid_i = 1'b1; ready_i = 3'b111;
      @(negedge clk_sys);
      valid_i = 1'b0; data_i = $urandom;
      for (int k = 0; k < 4; k++) begin
         #1;
         vectors += 4;
         if (valid_o !== 3'b010) begin miscompares++; $display("FAIL single_valid[%0d]: got %b expected 010", k, valid_o); end
         if (data_o !== lane(exp_byte(w, k, 1'b1), 1)) begin
            miscompares++; $display("FAIL single_data[%0d]: got %h expected %h", k, data_o, lane(exp_byte(w, k, 1'b1), 1));
         end
         if (ready_o !== (k == 3)) begin miscompares++; $display("FAIL single_ready[%0d]: got %b expected %b", k, ready_o, (k == 3)); end
         if (lsb_data_o !== lane(exp_byte(w, k, 1'b0), 1)) begin
            miscompares++; $display("FAIL lsb_order[%0d]: got %h expected %h", k, lsb_data_o, lane(exp_byte(w, k, 1'b0), 1));
         end
         @(negedge clk_sys);
      end
      #1;
      vectors++;
      if (valid_o !== 3'b000) begin miscompares++; $display("FAIL single_end_valid: got %b expected 000", valid_o); end
      @(negedge clk_sys);
   endtask

   task automatic test_back_to_back();
      logic [31:0] w1, w2;
      logic [7:0]  eb;
      logic [2:0]  ev;
      int          ch;
      w1 = 32'h11223344; w2 = 32'h55667788;
      apply_reset();
      data_i = w1; select = 2'd0; valid_i = 1'b1; ready_i = 3'b111;
      @(negedge clk_sys);
      data_i = w2; select = 2'd2;
      for (int k = 0; k < 8; k++) begin
         ch = (k < 4) ? 0 : 2;
         eb = (k < 4) ? exp_byte(w1, k, 1'b1) : exp_byte(w2, k - 4, 1'b1);
         ev = 3'b001 << ch;
         #1;
         vectors += 3;
         if (valid_o !== ev) begin miscompares++; $display("FAIL b2b_valid[%0d]: got %b expected %b", k, valid_o, ev); end
         if (data_o !== lane(eb, ch)) begin miscompares++; $display("FAIL b2b_data[%0d]: got %h expected %h", k, data_o, lane(eb, ch)); end
         if (ready_o !== ((k == 3) || (k == 7))) begin
            miscompares++; $display("FAIL b2b_ready[%0d]: got %b expected %b", k, ready_o, ((k == 3) || (k == 7)));
         end
         @(negedge clk_sys);
         if (k == 3) valid_i = 1'b0;
      end
   endtask

   task automatic test_backpressure();
      logic [7:0] exp_b [6];
      logic       rdy2  [6];
      exp_b = '{8'h55, 8'h66, 8'h66, 8'h66, 8'h77, 8'h88};
      rdy2  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
      apply_reset();
      data_i = 32'h55667788; select = 2'd2; valid_i = 1'b1; ready_i = 3'b111;
      @(negedge clk_sys);
      valid_i = 1'b0;
      for (int k = 0; k < 6; k++) begin
         ready_i = {rdy2[k], 1'($urandom_range(0, 1)), 1'(k % 2)};
         #1;
         vectors += 2;
         if (valid_o !== 3'b100) begin miscompares++; $display("FAIL bp_valid[%0d]: got %b expected 100", k, valid_o); end
         if (data_o !== lane(exp_b[k], 2)) begin miscompares++; $display("FAIL bp_data[%0d]: got %h expected %h", k, data_o, lane(exp_b[k], 2)); end
         @(negedge clk_sys);
      end
      #1;
      vectors++;
      if (valid_o !== 3'b000) begin miscompares++; $display("FAIL bp_end_valid: got %b expected 000", valid_o); end
      @(negedge clk_sys);
   endtask

   task automatic test_drop();
      apply_reset();
      data_i = 32'hDEADBEEF; select = 2'd3; valid_i = 1'b1; ready_i = 3'b111;
      #1;
      vectors++;
      if (ready_o !== 1'b1) begin miscompares++; $display("FAIL drop_pre_ready: got %b expected 1", ready_o); end
      @(negedge clk_sys);
      valid_i = 1'b0;
      #1;
      vectors += 4;
      if (drop_o !== 1'b1) begin miscompares++; $display("FAIL drop_pulse: got %b expected 1", drop_o); end
      if (valid_o !== 3'b000) begin miscompares++; $display("FAIL drop_valid: got %b expected 000", valid_o); end
      if (ready_o !== 1'b1) begin miscompares++; $display("FAIL drop_ready: got %b expected 1", ready_o); end
      if (data_o !== 24'h0) begin miscompares++; $display("FAIL drop_data: got %h expected 000000", data_o); end
      @(negedge clk_sys);
      #1;
      vectors += 2;
      if (drop_o !== 1'b0) begin miscompares++; $display("FAIL drop_once: got %b expected 0", drop_o); end
      if (valid_o !== 3'b000) begin miscompares++; $display("FAIL drop_valid2: got %b expected 000", valid_o); end
      @(negedge clk_sys);
   endtask

   task automatic test_async_reset();
      apply_reset();
      data_i = 32'hA1B2C3D4; select = 2'd1; valid_i = 1'b1; ready_i = 3'b111;
      @(negedge clk_sys);
      valid_i = 1'b0;
      repeat (2) @(negedge clk_sys);
      #1;
      vectors++;
      if (data_o !== lane(8'hC3, 1)) begin miscompares++; $display("FAIL arst_beat2: got %h expected %h", data_o, lane(8'hC3, 1)); end
      #1 rst_n = 1'b0;
      #1;
      vectors += 4;
      if (valid_o !== 3'b000) begin miscompares++; $display("FAIL arst_valid: got %b expected 000", valid_o); end
      if (data_o !== 24'h0) begin miscompares++; $display("FAIL arst_data: got %h expected 000000", data_o); end
      if (ready_o !== 1'b1) begin miscompares++; $display("FAIL arst_ready: got %b expected 1", ready_o); end
      if (lsb_valid_o !== 3'b000) begin miscompares++; $display("FAIL arst_lsb_valid: got %b expected 000", lsb_valid_o); end
      @(negedge clk_sys);
      rst_n = 1'b1;
      data_i = 32'h01020304; select = 2'd0; valid_i = 1'b1;
      @(negedge clk_sys);
      valid_i = 1'b0;
      #1;
      vectors += 2;
      if (valid_o !== 3'b001) begin miscompares++; $display("FAIL arst_restart_valid: got %b expected 001", valid_o); end
      if (data_o !== lane(8'h01, 0)) begin miscompares++; $display("FAIL arst_restart_data: got %h expected %h", data_o, lane(8'h01, 0)); end
      @(negedge clk_sys);
   endtask

   // Model: the block emits a single global stream of beats; the head of the
   // queue is what is on the wire, and a word is taken when the queue is
   // empty or is about to lose its final beat.
   task automatic test_random();
      beat_t       q[$];
      beat_t       b;
      logic        exp_drop;
      logic        er;
      logic [2:0]  ev;
      logic [23:0] ed;
      apply_reset();
      exp_drop = 1'b0;
      for (int n = 0; n < 800; n++) begin
         valid_i = 1'($urandom_range(0, 1));
         select  = ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
         data_i  = $urandom;
         for (int c = 0; c < 3; c++) ready_i[c] = ($urandom_range(0, 3) != 0);
         #1;
         if (q.size() == 0) begin
            ev = 3'b000; ed = 24'h0; er = 1'b1;
         end else begin
            ev = 3'b001 << q[0].ch;
            ed = lane(q[0].d, q[0].ch);
            er = (q.size() == 1) && ready_i[q[0].ch];
         end
         vectors += 4;
         if (valid_o !== ev) begin miscompares++; $display("FAIL rnd_valid@%0d: got %b expected %b", n, valid_o, ev); end
         if (data_o !== ed) begin miscompares++; $display("FAIL rnd_data@%0d: got %h expected %h", n, data_o, ed); end
         if (ready_o !== er) begin miscompares++; $display("FAIL rnd_ready@%0d: got %b expected %b", n, ready_o, er); end
         if (drop_o !== exp_drop) begin miscompares++; $display("FAIL rnd_drop@%0d: got %b expected %b", n, drop_o, exp_drop); end
         exp_drop = 1'b0;
         if ((q.size() > 0) && ready_i[q[0].ch]) void'(q.pop_front());
         if (valid_i && er) begin
            if (select < 2'd3) begin
               for (int k = 0; k < 4; k++) begin
                  b.ch = int'(select);
                  b.d  = exp_byte(data_i, k, 1'b1);
                  q.push_back(b);
               end
            end else begin
               exp_drop = 1'b1;
            end
         end
         @(negedge clk_sys);
      end
   endtask

   initial begin
      rst_n = 1'b0; valid_i = 1'b0; select = 2'd0; data_i = 32'h0; ready_i = 3'b000;
      @(negedge clk_sys);
      test_reset();
      test_single();
      test_back_to_back();
      test_backpressure();
      test_drop();
      test_async_reset();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation still running at %0t", $time);
      $fatal(1, "watchdog expired");
   end

endmodule
